// File: rtl/frame_ring_ctrl.sv
// Frame ring controller: hands DDR frame slots to a capture path (writer) and a host (reader),
// tracking complete unread frames and timing out captures that never commit.
module frame_ring_ctrl #(
    parameter int          NUM_BUFS   = 4,
    parameter logic [29:0] BASE_ADDR  = 30'h0000000,
    parameter logic [29:0] BUF_STRIDE = 30'h0800000,
    parameter logic [23:0] TIMEOUT    = 24'd16000000
) (
    input  logic        clk,
    input  logic        mem_reset,
    input  logic        capture_en,
    input  logic        single_shot,
    output logic        trigger,
    output logic [29:0] wr_start_addr,
    input  logic        frame_written,
    input  logic        rd_req,
    output logic        rd_ack,
    output logic [29:0] rd_start_addr,
    input  logic        rd_done,
    output logic [3:0]  buf_count,
    output logic        stall,
    output logic [7:0]  timeout_count
);

    localparam int              PTR_W      = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_BUFS - 1);
    localparam logic [3:0]      FULL_COUNT = 4'(NUM_BUFS);

    typedef enum logic {W_IDLE, W_ARM}  wr_state_t;
    typedef enum logic {R_IDLE, R_BUSY} rd_state_t;

    // Slot base addresses are constants, so the ring address is a table lookup.
    logic [29:0] slot_addr [NUM_BUFS];
    for (genvar gi = 0; gi < NUM_BUFS; gi++) begin : g_slot
        assign slot_addr[gi] = BASE_ADDR + 30'(gi) * BUF_STRIDE;
    end

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    wr_state_t        wr_state_reg, wr_state_next;
    rd_state_t        rd_state_reg, rd_state_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [3:0]       buf_count_reg, buf_count_next;
    logic             pending_reg, pending_next;
    logic [1:0]       arm_ok_reg, arm_ok_next;
    logic [23:0]      to_cnt_reg, to_cnt_next;
    logic [7:0]       timeout_count_reg, timeout_count_next;
    logic             trigger_reg, trigger_next;
    logic             stall_reg, stall_next;
    logic [29:0]      wr_start_addr_reg, wr_start_addr_next;
    logic [29:0]      rd_start_addr_reg, rd_start_addr_next;

    logic capture_req;
    logic fw_acc;
    logic rd_acc;

    always_comb begin
        wr_state_next      = wr_state_reg;
        rd_state_next      = rd_state_reg;
        wr_ptr_next        = wr_ptr_reg;
        rd_ptr_next        = rd_ptr_reg;
        buf_count_next     = buf_count_reg;
        pending_next       = pending_reg | single_shot;
        arm_ok_next        = {arm_ok_reg[0], 1'b1};
        to_cnt_next        = to_cnt_reg;
        timeout_count_next = timeout_count_reg;
        trigger_next       = 1'b0;
        rd_start_addr_next = rd_start_addr_reg;
        fw_acc             = 1'b0;
        rd_acc             = 1'b0;
        capture_req        = capture_en | pending_reg;

        case (wr_state_reg)
            W_IDLE: begin
                to_cnt_next = '0;
                // arm_ok holds off the first trigger for two edges after reset release
                if (capture_req && (buf_count_reg < FULL_COUNT) && arm_ok_reg[1]) begin
                    wr_state_next = W_ARM;
                    trigger_next  = 1'b1;
                    pending_next  = single_shot;
                end
            end
            W_ARM: begin
                if (frame_written) begin
                    fw_acc        = 1'b1;
                    wr_state_next = W_IDLE;
                    wr_ptr_next   = next_ptr(wr_ptr_reg);
                    to_cnt_next   = '0;
                end else if (to_cnt_reg == TIMEOUT - 24'd1) begin
                    wr_state_next = W_IDLE;
                    to_cnt_next   = '0;
                    if (timeout_count_reg != 8'hFF) begin
                        timeout_count_next = timeout_count_reg + 8'd1;
                    end
                end else begin
                    to_cnt_next = to_cnt_reg + 24'd1;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase

        case (rd_state_reg)
            R_IDLE: begin
                if (rd_req && (buf_count_reg != 4'd0)) begin
                    rd_state_next      = R_BUSY;
                    rd_start_addr_next = slot_addr[rd_ptr_reg];
                end
            end
            R_BUSY: begin
                if (rd_done) begin
                    rd_acc        = 1'b1;
                    rd_state_next = R_IDLE;
                    rd_ptr_next   = next_ptr(rd_ptr_reg);
                end
            end
            default: rd_state_next = R_IDLE;
        endcase

        case ({fw_acc, rd_acc})
            2'b10:   buf_count_next = buf_count_reg + 4'd1;
            2'b01:   buf_count_next = buf_count_reg - 4'd1;
            default: buf_count_next = buf_count_reg;
        endcase

        // Tracking wr_ptr keeps the address stable long before and throughout W_ARM.
        wr_start_addr_next = slot_addr[wr_ptr_next];
        stall_next = (wr_state_reg == W_IDLE) && capture_req && (buf_count_reg == FULL_COUNT);
    end

    always_ff @(posedge clk or posedge mem_reset) begin
        if (mem_reset) begin
            wr_state_reg      <= W_IDLE;
            rd_state_reg      <= R_IDLE;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            buf_count_reg     <= '0;
            pending_reg       <= 1'b0;
            arm_ok_reg        <= '0;
            to_cnt_reg        <= '0;
            timeout_count_reg <= '0;
            trigger_reg       <= 1'b0;
            stall_reg         <= 1'b0;
            wr_start_addr_reg <= BASE_ADDR;
            rd_start_addr_reg <= BASE_ADDR;
        end else begin
            wr_state_reg      <= wr_state_next;
            rd_state_reg      <= rd_state_next;
            wr_ptr_reg        <= wr_ptr_next;
            rd_ptr_reg        <= rd_ptr_next;
            buf_count_reg     <= buf_count_next;
            pending_reg       <= pending_next;
            arm_ok_reg        <= arm_ok_next;
            to_cnt_reg        <= to_cnt_next;
            timeout_count_reg <= timeout_count_next;
            trigger_reg       <= trigger_next;
            stall_reg         <= stall_next;
            wr_start_addr_reg <= wr_start_addr_next;
            rd_start_addr_reg <= rd_start_addr_next;
        end
    end

    assign trigger       = trigger_reg;
    assign wr_start_addr = wr_start_addr_reg;
    assign rd_ack        = (rd_state_reg == R_BUSY);
    assign rd_start_addr = rd_start_addr_reg;
    assign buf_count     = buf_count_reg;
    assign stall         = stall_reg;
    assign timeout_count = timeout_count_reg;

endmodule

// File: tb/tb_frame_ring_ctrl.sv
// Scoreboarded bench for frame_ring_ctrl: expected trigger/grant addresses are queued by the
// stimulus and consumed by a monitor; a second instance with a short timeout covers timeouts.
module tb_frame_ring_ctrl;

    logic        clk = 1'b0;
    logic        mem_reset = 1'b1;
    logic        capture_en = 1'b0, single_shot = 1'b0, frame_written = 1'b0;
    logic        rd_req = 1'b0, rd_done = 1'b0;
    logic        trigger, rd_ack, stall;
    logic [29:0] wr_start_addr, rd_start_addr;
    logic [3:0]  buf_count;
    logic [7:0]  timeout_count;

    logic        capture_en_b = 1'b0, single_shot_b = 1'b0;
    logic        trigger_b, rd_ack_b, stall_b;
    logic [29:0] wr_start_addr_b, rd_start_addr_b;
    logic [3:0]  buf_count_b;
    logic [7:0]  timeout_count_b;

    int errors = 0;
    int checks = 0;
    int trig_cnt = 0;
    logic ack_prev = 1'b0;
    logic [29:0] exp_trig[$];
    logic [29:0] exp_rd[$];

    always #5 clk = ~clk;

    frame_ring_ctrl dut (
        .clk(clk), .mem_reset(mem_reset), .capture_en(capture_en), .single_shot(single_shot),
        .trigger(trigger), .wr_start_addr(wr_start_addr), .frame_written(frame_written),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_start_addr(rd_start_addr), .rd_done(rd_done),
        .buf_count(buf_count), .stall(stall), .timeout_count(timeout_count)
    );

    frame_ring_ctrl #(.TIMEOUT(24'd50)) dut_to (
        .clk(clk), .mem_reset(mem_reset), .capture_en(capture_en_b), .single_shot(single_shot_b),
        .trigger(trigger_b), .wr_start_addr(wr_start_addr_b), .frame_written(1'b0),
        .rd_req(1'b0), .rd_ack(rd_ack_b), .rd_start_addr(rd_start_addr_b), .rd_done(1'b0),
        .buf_count(buf_count_b), .stall(stall_b), .timeout_count(timeout_count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every trigger and every new grant must match the head of its queue.
    always @(negedge clk) begin
        if (mem_reset) begin
            ack_prev = 1'b0;
        end else begin
            if (trigger) begin
                trig_cnt++;
                if (exp_trig.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_trigger: got addr 0x%0h expected no trigger", wr_start_addr);
                end else begin
                    check("trigger_addr", 32'(wr_start_addr), 32'(exp_trig.pop_front()));
                end
            end
            if (rd_ack && !ack_prev) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got addr 0x%0h expected no grant", rd_start_addr);
                end else begin
                    check("grant_addr", 32'(rd_start_addr), 32'(exp_rd.pop_front()));
                end
            end
            ack_prev = rd_ack;
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic pulse_fw();  @(posedge clk); #1 frame_written = 1'b1; @(posedge clk); #1 frame_written = 1'b0; endtask
    task automatic pulse_done(); @(posedge clk); #1 rd_done = 1'b1; @(posedge clk); #1 rd_done = 1'b0; endtask
    task automatic pulse_ss();  @(posedge clk); #1 single_shot = 1'b1; @(posedge clk); #1 single_shot = 1'b0; endtask
    task automatic pulse_ss_b(); @(posedge clk); #1 single_shot_b = 1'b1; @(posedge clk); #1 single_shot_b = 1'b0; endtask
    task automatic pulse_both();
        @(posedge clk); #1 frame_written = 1'b1; rd_done = 1'b1;
        @(posedge clk); #1 frame_written = 1'b0; rd_done = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 mem_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_reset = 1'b0;
    endtask

    task automatic wait_trig(input string name, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (trigger) begin seen = 1'b1; break; end
        end
        if (!seen) begin checks++; errors++; $display("FAIL %s: got no trigger expected trigger within %0d cycles", name, limit); end
    endtask

    task automatic wait_ack(input string name, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rd_ack) begin seen = 1'b1; break; end
        end
        if (!seen) begin checks++; errors++; $display("FAIL %s: got no rd_ack expected rd_ack within %0d cycles", name, limit); end
    endtask

    task automatic wait_trig_b(input string name, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (trigger_b) begin seen = 1'b1; break; end
        end
        if (!seen) begin checks++; errors++; $display("FAIL %s: got no trigger expected trigger within %0d cycles", name, limit); end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trigger"}, 32'(trigger), 32'd0);
        check({tag, "_rd_ack"}, 32'(rd_ack), 32'd0);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_buf_count"}, 32'(buf_count), 32'd0);
        check({tag, "_timeout_count"}, 32'(timeout_count), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_start_addr), 32'h0);
        check({tag, "_rd_addr"}, 32'(rd_start_addr), 32'h0);
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 mem_reset = 1'b0;
        repeat (3) tick();

        // Single shot: one trigger at slot 0, one frame stored, nothing else.
        trig_cnt = 0;
        exp_trig.push_back(30'h0000000);
        pulse_ss();
        wait_trig("ss_trigger", 20);
        repeat (100) tick();
        pulse_fw();
        repeat (20) tick();
        check("ss_buf_count", 32'(buf_count), 32'd1);
        check("ss_trig_cnt", 32'(trig_cnt), 32'd1);

        // Short-timeout instance: timeout exactly 50 cycles after trigger, same slot reused.
        pulse_ss_b();
        wait_trig_b("to_trigger", 20);
        check("to_trig_addr", 32'(wr_start_addr_b), 32'h0);
        k = 0;
        while (timeout_count_b == 8'd0 && k < 100) begin @(negedge clk); k++; end
        check("to_cycles", 32'(k), 32'd50);
        check("to_count", 32'(timeout_count_b), 32'd1);
        check("to_buf_count", 32'(buf_count_b), 32'd0);
        pulse_ss_b();
        wait_trig_b("to_retrigger", 20);
        check("to_retrig_addr", 32'(wr_start_addr_b), 32'h0);
        @(posedge clk); #1 capture_en_b = 1'b1;
        k = 0;
        while (timeout_count_b != 8'hFF && k < 16000) begin @(negedge clk); k++; end
        repeat (120) @(negedge clk);
        check("to_saturate", 32'(timeout_count_b), 32'hFF);
        capture_en_b = 1'b0;

        // Continuous capture fills the ring; no trigger within two edges of reset release.
        trig_cnt = 0;
        exp_trig.push_back(30'h0000000);
        exp_trig.push_back(30'h0800000);
        exp_trig.push_back(30'h1000000);
        exp_trig.push_back(30'h1800000);
        capture_en = 1'b1;
        do_reset();
        @(negedge clk);
        @(negedge clk); check("rel_trigger_1", 32'(trigger), 32'd0);
        @(negedge clk); check("rel_trigger_2", 32'(trigger), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_trig("fill_trigger", 20);
            repeat (5) tick();
            pulse_fw();
        end
        repeat (10) tick();
        check("full_buf_count", 32'(buf_count), 32'd4);
        check("full_stall", 32'(stall), 32'd1);
        check("full_trig_cnt", 32'(trig_cnt), 32'd4);

        // Read oldest from a full ring; the freed slot 0 is captured next.
        exp_rd.push_back(30'h0000000);
        rd_req = 1'b1;
        wait_ack("full_grant", 20);
        @(posedge clk); #1 rd_req = 1'b0;
        exp_trig.push_back(30'h0000000);
        pulse_done();
        wait_trig("wrap_trigger", 20);
        check("wrap_stall", 32'(stall), 32'd0);
        check("wrap_buf_count", 32'(buf_count), 32'd3);
        check("wrap_rd_ack", 32'(rd_ack), 32'd0);
        capture_en = 1'b0;
        repeat (3) tick();
        pulse_fw();
        tick();

        // Simultaneous commit and release with two frames stored.
        exp_trig.push_back(30'h0000000);
        exp_trig.push_back(30'h0800000);
        exp_trig.push_back(30'h1000000);
        capture_en = 1'b1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wait_trig("both_fill", 20);
            repeat (3) tick();
            pulse_fw();
        end
        wait_trig("both_arm", 20);
        capture_en = 1'b0;
        check("both_pre_count", 32'(buf_count), 32'd2);
        exp_rd.push_back(30'h0000000);
        rd_req = 1'b1;
        wait_ack("both_grant", 20);
        @(posedge clk); #1 rd_req = 1'b0;
        pulse_both();
        @(negedge clk);
        check("both_buf_count", 32'(buf_count), 32'd2);
        check("both_rd_ack", 32'(rd_ack), 32'd0);
        tick();
        exp_rd.push_back(30'h0800000);
        rd_req = 1'b1;
        wait_ack("both_next_grant", 20);
        @(posedge clk); #1 rd_req = 1'b0;
        pulse_done();
        exp_trig.push_back(30'h1800000);
        pulse_ss();
        wait_trig("both_next_trigger", 20);
        repeat (2) tick();
        pulse_fw();
        tick();
        check("both_final_count", 32'(buf_count), 32'd2);

        // Asynchronous reset while capturing and reading discards both transfers.
        exp_trig.push_back(30'h0000000);
        pulse_ss();
        wait_trig("rst_trigger", 20);
        exp_rd.push_back(30'h1000000);
        rd_req = 1'b1;
        wait_ack("rst_grant", 20);
        #2 mem_reset = 1'b1; rd_req = 1'b0;
        #1 check_reset_outputs("async");
        @(posedge clk); #1 mem_reset = 1'b0;
        repeat (3) tick();
        pulse_both();
        repeat (3) tick();
        check("post_rst_buf_count", 32'(buf_count), 32'd0);
        check("post_rst_rd_ack", 32'(rd_ack), 32'd0);
        check("trig_queue_drained", 32'(exp_trig.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
